// File: rtl/event_arbiter_if.sv
// Handshake bundle linking the event capture sources, the arbiter and the
// convolution engine event port.
interface event_arbiter_if #(
  parameter int N_SRC      = 4,
  parameter int COORD_BITS = 8
);
  localparam int SRC_BITS = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0]              src_valid;
  logic [N_SRC*2*COORD_BITS-1:0] src_coord;
  logic [N_SRC-1:0]              src_ack;
  logic                          out_valid;
  logic [2*COORD_BITS-1:0]       out_coord;
  logic [SRC_BITS-1:0]           out_src;
  logic                          out_ack;

  // The environment (sources plus engine) sits on the master side.
  modport master (
    output src_valid, src_coord, out_ack,
    input  src_ack, out_valid, out_coord, out_src
  );

  modport slave (
    input  src_valid, src_coord, out_ack,
    output src_ack, out_valid, out_coord, out_src
  );
endinterface

// File: rtl/event_arbiter.sv
// Round-robin arbiter forwarding one coordinate event at a time from N_SRC
// capture channels to the convolution engine, with a timestep flush barrier.
module event_arbiter #(
  parameter int N_SRC      = 4,
  parameter int COORD_BITS = 8,
  parameter int CNT_BITS   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  event_arbiter_if.slave      bus,
  input  logic                i_enable,
  input  logic                i_flush_req,
  output logic                o_flush_done,
  output logic [CNT_BITS-1:0] o_evt_count,
  output logic                o_active
);
  localparam int SRC_BITS = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int EVT_BITS = 2 * COORD_BITS;
  localparam int IDX_BITS = SRC_BITS + 1;

  typedef enum logic {
    IDLE,
    OUTPUT
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [SRC_BITS-1:0]   r_rr_ptr;
  logic                  r_flush_pending;
  logic [N_SRC-1:0]      r_src_ack;
  logic [EVT_BITS-1:0]   r_out_coord;
  logic [SRC_BITS-1:0]   r_out_src;
  logic                  r_flush_done;
  logic [CNT_BITS-1:0]   r_evt_count;

  logic [SRC_BITS-1:0]   w_win;
  logic [IDX_BITS-1:0]   w_idx;
  logic                  w_grant;
  logic                  w_flush;
  logic                  w_release;

  // Descending scan so the source closest to rr_ptr overwrites the others.
  always_comb begin
    w_win = '0;
    w_idx = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      w_idx = {1'b0, r_rr_ptr} + IDX_BITS'(k);
      if (w_idx >= IDX_BITS'(N_SRC)) begin
        w_idx = w_idx - IDX_BITS'(N_SRC);
      end
      if (bus.src_valid[w_idx]) begin
        w_win = w_idx[SRC_BITS-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    w_flush      = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_flush_pending) begin
          w_flush = 1'b1;
        end else if (i_enable && (|bus.src_valid)) begin
          w_grant      = 1'b1;
          w_next_state = OUTPUT;
        end
      end
      OUTPUT: begin
        if (bus.out_ack) begin
          w_release    = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // A flush request landing on the servicing edge re-arms the barrier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr        <= '0;
      r_flush_pending <= 1'b0;
      r_src_ack       <= '0;
      r_out_coord     <= '0;
      r_out_src       <= '0;
      r_flush_done    <= 1'b0;
      r_evt_count     <= '0;
    end else begin
      r_src_ack       <= '0;
      r_flush_done    <= 1'b0;
      r_flush_pending <= i_flush_req | (r_flush_pending & ~w_flush);
      if (w_flush) begin
        r_flush_done <= 1'b1;
        r_evt_count  <= '0;
      end
      if (w_grant) begin
        r_out_coord      <= bus.src_coord[w_win*EVT_BITS +: EVT_BITS];
        r_out_src        <= w_win;
        r_src_ack[w_win] <= 1'b1;
      end
      if (w_release) begin
        r_rr_ptr    <= (r_out_src == SRC_BITS'(N_SRC - 1)) ? '0
                                                           : r_out_src + SRC_BITS'(1);
        r_evt_count <= r_evt_count + CNT_BITS'(1);
      end
    end
  end

  always_comb begin
    bus.out_valid = (r_state == OUTPUT);
    bus.out_coord = r_out_coord;
    bus.out_src   = r_out_src;
    bus.src_ack   = r_src_ack;
    o_flush_done  = r_flush_done;
    o_evt_count   = r_evt_count;
    o_active      = (r_state != IDLE) || r_flush_pending;
  end
endmodule

// File: tb/tb_event_arbiter.sv
// Self-checking bench for event_arbiter: directed vector table, hand-written
// corner sequences and a randomized run against a transaction-level model.
module tb_event_arbiter;
  localparam int N  = 4;
  localparam int CB = 8;
  localparam int CW = 16;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        flushReq;
  logic        flushDone;
  logic [15:0] evtCount;
  logic        active;

  int checks = 0;
  int errors = 0;

  event_arbiter_if #(.N_SRC(N), .COORD_BITS(CB)) bus ();

  event_arbiter #(.N_SRC(N), .COORD_BITS(CB), .CNT_BITS(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .i_enable    (enable),
    .i_flush_req (flushReq),
    .o_flush_done(flushDone),
    .o_evt_count (evtCount),
    .o_active    (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [3:0]  valid;
    logic        ack;
    logic        flush;
    logic        expValid;
    logic [1:0]  expSrc;
    logic [3:0]  expAck;
    logic        expFd;
    logic [15:0] expCnt;
    logic        expAct;
  } vec_t;

  vec_t        vecs [17];
  logic [15:0] coordArr [4];

  // Reference model state (transaction level)
  logic        mBusy;
  int          mPtr;
  logic        mPending;
  int          mSrc;
  logic [15:0] mCoord;
  logic [3:0]  mAck;
  logic        mFd;
  logic [15:0] mCount;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic packCoords();
    for (int i = 0; i < N; i++) bus.src_coord[i*CW +: CW] = coordArr[i];
  endtask

  task automatic applyStimulus(input logic en, input logic [3:0] valid,
                               input logic ack, input logic flush);
    enable        = en;
    bus.src_valid = valid;
    bus.out_ack   = ack;
    flushReq      = flush;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic modelStep();
    logic [3:0] nAck;
    logic       nFd;
    int         idx;
    nAck = '0;
    nFd  = 1'b0;
    if (!mBusy) begin
      if (mPending) begin
        nFd      = 1'b1;
        mCount   = '0;
        mPending = 1'b0;
      end else if (enable && bus.src_valid != 4'b0000) begin
        for (int k = 0; k < N; k++) begin
          idx = (mPtr + k) % N;
          if (bus.src_valid[idx]) begin
            mSrc      = idx;
            mCoord    = coordArr[idx];
            nAck[idx] = 1'b1;
            mBusy     = 1'b1;
            break;
          end
        end
      end
    end else if (bus.out_ack) begin
      mBusy  = 1'b0;
      mPtr   = (mSrc + 1) % N;
      mCount = mCount + 16'd1;
    end
    if (flushReq) mPending = 1'b1;
    mAck = nAck;
    mFd  = nFd;
  endtask

  initial begin
    coordArr[0] = 16'h1100;
    coordArr[1] = 16'h2211;
    coordArr[2] = 16'h0A05;
    coordArr[3] = 16'h4433;
    packCoords();

    //             en    valid    ack   flush  expV  src   expAck   fd    cnt     act
    vecs[0]  = '{1'b1, 4'b0100, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b0, 16'd0, 1'b1};
    vecs[1]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0000, 1'b0, 16'd0, 1'b1};
    vecs[2]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0000, 1'b0, 16'd1, 1'b0};
    vecs[3]  = '{1'b1, 4'b1111, 1'b0, 1'b0, 1'b1, 2'd3, 4'b1000, 1'b0, 16'd1, 1'b1};
    vecs[4]  = '{1'b1, 4'b0111, 1'b1, 1'b0, 1'b0, 2'd3, 4'b0000, 1'b0, 16'd2, 1'b0};
    vecs[5]  = '{1'b1, 4'b0111, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b0, 16'd2, 1'b1};
    vecs[6]  = '{1'b1, 4'b0110, 1'b0, 1'b1, 1'b1, 2'd0, 4'b0000, 1'b0, 16'd2, 1'b1};
    vecs[7]  = '{1'b1, 4'b0110, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 16'd3, 1'b1};
    vecs[8]  = '{1'b1, 4'b0110, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 16'd0, 1'b0};
    vecs[9]  = '{1'b1, 4'b0110, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b0, 16'd0, 1'b1};
    vecs[10] = '{1'b1, 4'b0100, 1'b1, 1'b0, 1'b0, 2'd1, 4'b0000, 1'b0, 16'd1, 1'b0};
    vecs[11] = '{1'b0, 4'b1111, 1'b0, 1'b0, 1'b0, 2'd1, 4'b0000, 1'b0, 16'd1, 1'b0};
    vecs[12] = '{1'b0, 4'b1111, 1'b0, 1'b1, 1'b0, 2'd1, 4'b0000, 1'b0, 16'd1, 1'b1};
    vecs[13] = '{1'b0, 4'b1111, 1'b0, 1'b1, 1'b0, 2'd1, 4'b0000, 1'b1, 16'd0, 1'b1};
    vecs[14] = '{1'b0, 4'b1111, 1'b0, 1'b0, 1'b0, 2'd1, 4'b0000, 1'b1, 16'd0, 1'b0};
    vecs[15] = '{1'b1, 4'b1111, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b0, 16'd0, 1'b1};
    vecs[16] = '{1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0000, 1'b0, 16'd1, 1'b0};

    // ---------------- reset state ----------------
    doReset();
    checkOutput("reset_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset_coord", 32'(bus.out_coord), 32'd0);
    checkOutput("reset_src",   32'(bus.out_src),   32'd0);
    checkOutput("reset_ack",   32'(bus.src_ack),   32'd0);
    checkOutput("reset_fd",    32'(flushDone),     32'd0);
    checkOutput("reset_cnt",   32'(evtCount),      32'd0);
    checkOutput("reset_act",   32'(active),        32'd0);

    // ---------------- directed vector table ----------------
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].en, vecs[i].valid, vecs[i].ack, vecs[i].flush);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(vecs[i].expValid));
      checkOutput($sformatf("vec%0d_src", i),   32'(bus.out_src),   32'(vecs[i].expSrc));
      checkOutput($sformatf("vec%0d_coord", i), 32'(bus.out_coord), 32'(coordArr[vecs[i].expSrc]));
      checkOutput($sformatf("vec%0d_ack", i),   32'(bus.src_ack),   32'(vecs[i].expAck));
      checkOutput($sformatf("vec%0d_fd", i),    32'(flushDone),     32'(vecs[i].expFd));
      checkOutput($sformatf("vec%0d_cnt", i),   32'(evtCount),      32'(vecs[i].expCnt));
      checkOutput($sformatf("vec%0d_act", i),   32'(active),        32'(vecs[i].expAct));
      @(negedge clk);
    end

    // ---------------- fairness: all sources, out_ack tied high ----------------
    doReset();
    applyStimulus(1'b1, 4'b1111, 1'b1, 1'b0);
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (c % 2 == 0) begin
        checkOutput($sformatf("fair%0d_valid", c), 32'(bus.out_valid), 32'd1);
        checkOutput($sformatf("fair%0d_src", c),   32'(bus.out_src),   32'((c / 2) % N));
        checkOutput($sformatf("fair%0d_ack", c),   32'(bus.src_ack),   32'(1) << ((c / 2) % N));
      end else begin
        checkOutput($sformatf("fair%0d_valid", c), 32'(bus.out_valid), 32'd0);
        checkOutput($sformatf("fair%0d_ack", c),   32'(bus.src_ack),   32'd0);
      end
    end
    @(negedge clk);

    // ---------------- backpressure: 10 cycles of out_ack low ----------------
    doReset();
    applyStimulus(1'b1, 4'b1010, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("bp_grant_ack", 32'(bus.src_ack), 32'b0010);
    @(negedge clk);
    applyStimulus(1'b1, 4'b1000, 1'b0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("bp%0d_valid", c), 32'(bus.out_valid), 32'd1);
      checkOutput($sformatf("bp%0d_src", c),   32'(bus.out_src),   32'd1);
      checkOutput($sformatf("bp%0d_coord", c), 32'(bus.out_coord), 32'(coordArr[1]));
      checkOutput($sformatf("bp%0d_ack", c),   32'(bus.src_ack),   32'd0);
    end
    @(negedge clk);
    applyStimulus(1'b1, 4'b1000, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("bp_release_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("bp_release_cnt",   32'(evtCount),      32'd1);
    @(negedge clk);
    applyStimulus(1'b1, 4'b1000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("bp_next_ack", 32'(bus.src_ack), 32'b1000);
    checkOutput("bp_next_src", 32'(bus.out_src), 32'd3);
    @(negedge clk);

    // ---------------- reset mid-operation ----------------
    doReset();
    for (int e = 0; e < 5; e++) begin
      applyStimulus(1'b1, 4'b0001, 1'b0, 1'b0);
      @(negedge clk);
      applyStimulus(1'b1, 4'b0000, 1'b1, 1'b0);
      @(negedge clk);
    end
    checkOutput("rmo_cnt5", 32'(evtCount), 32'd5);
    applyStimulus(1'b1, 4'b0100, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("rmo_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rmo_coord", 32'(bus.out_coord), 32'd0);
    checkOutput("rmo_src",   32'(bus.out_src),   32'd0);
    checkOutput("rmo_ack",   32'(bus.src_ack),   32'd0);
    checkOutput("rmo_cnt",   32'(evtCount),      32'd0);
    checkOutput("rmo_act",   32'(active),        32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("rmo_first_ack", 32'(bus.src_ack), 32'b0001);
    checkOutput("rmo_first_src", 32'(bus.out_src), 32'd0);
    @(negedge clk);

    // ---------------- randomized run against reference model ----------------
    doReset();
    mBusy = 1'b0; mPtr = 0; mPending = 1'b0; mSrc = 0; mCoord = '0;
    mAck = '0; mFd = 1'b0; mCount = '0;
    for (int c = 0; c < 3000; c++) begin
      checkOutput("rnd_valid", 32'(bus.out_valid), 32'(mBusy));
      checkOutput("rnd_src",   32'(bus.out_src),   32'(mSrc));
      checkOutput("rnd_coord", 32'(bus.out_coord), 32'(mCoord));
      checkOutput("rnd_ack",   32'(bus.src_ack),   32'(mAck));
      checkOutput("rnd_fd",    32'(flushDone),     32'(mFd));
      checkOutput("rnd_cnt",   32'(evtCount),      32'(mCount));
      checkOutput("rnd_act",   32'(active),        32'(mBusy | mPending));
      for (int i = 0; i < N; i++) begin
        if (mAck[i]) begin
          bus.src_valid[i] = ($urandom_range(0, 1) == 1);
          coordArr[i]      = 16'($urandom);
        end else if (!bus.src_valid[i]) begin
          bus.src_valid[i] = ($urandom_range(0, 3) == 0);
          coordArr[i]      = 16'($urandom);
        end
      end
      packCoords();
      enable      = ($urandom_range(0, 7) != 0);
      bus.out_ack = ($urandom_range(0, 1) == 1);
      flushReq    = ($urandom_range(0, 15) == 0);
      modelStep();
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
